// File: rtl/fifo_ctrl.sv
// ============================================================================
// fifo_ctrl : wrap-bit pointer, occupancy and sticky-error controller for a
//             synchronous FIFO.                                  Rev 1.0
// ============================================================================
`default_nettype none

module fifo_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 2**ADDR_WIDTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_req,
  input  logic                  read_req,
  input  logic                  clr_err,
  output logic                  write_ena,
  output logic                  read_ena,
  output logic [ADDR_WIDTH:0]   write_addr,
  output logic [ADDR_WIDTH:0]   read_addr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int              PW     = ADDR_WIDTH + 1;
  localparam logic [PW-1:0]   AF_LVL = PW'(AF_THRESH);
  localparam logic [PW-1:0]   AE_LVL = PW'(AE_THRESH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  // Equal low bits with differing wrap bits means the writer is a full lap ahead.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                 (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);

  assign write_ena = write_req & ~full  & ~rst;
  assign read_ena  = read_req  & ~empty & ~rst;

  assign count        = wr_ptr_q - rd_ptr_q;
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);

  assign write_addr = wr_ptr_q;
  assign read_addr  = rd_ptr_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, write_ena};
    rd_ptr_d    = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, read_ena};
    // A new error on the same edge as clr_err must survive the clear.
    overflow_d  = (overflow_q  & ~clr_err) | (write_req & full);
    underflow_d = (underflow_q & ~clr_err) | (read_req  & empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

`default_nettype wire
